d_phy_clk_lane_ctrl: RTL

- Sequencer for the MIPI D-PHY v2.5 master Clock Lane behavioural model.
- Collects HS-transmission requests from N data lanes and drives the Clock Lane LP/HS state sequence: LP-11 → LP-01 → LP-00 → HS-0 → clock running → trail → LP-11.
- Gates the word-clock-derived HS clock and grants data lanes once T_CLK_PRE has elapsed.
- Sits between the data-lane models and the clock generator. Runs on the generator's word clock, so all timings are in word-clock cycles.

---
 rtl/d_phy_pkg.sv | 33 +++
 rtl/d_phy_phase_timer.sv | 45 ++++
 rtl/d_phy_clk_lane_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/d_phy_pkg.sv
// Shared definitions for the D-PHY master Clock Lane sequencer.
//
// Contents:
//   clk_lane_state_t - Clock Lane sequence states, IDLE through EXIT
//   T_*              - power-on defaults for the timing shadow registers,
//                      in word-clock cycles
//   LOW / HIGH       - single-bit line levels used when decoding LP outputs
package d_phy_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LPX,
    PREPARE,
    ZERO,
    PRE,
    ACTIVE,
    POST,
    TRAIL,
    EXIT
  } clk_lane_state_t;

  localparam int T_LPX         = 2;
  localparam int T_CLK_PREPARE = 3;
  localparam int T_CLK_ZERO    = 12;
  localparam int T_CLK_PRE     = 2;
  localparam int T_CLK_POST    = 8;
  localparam int T_CLK_TRAIL   = 3;
  localparam int T_HS_EXIT     = 4;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

endpackage

// File: rtl/d_phy_phase_timer.sv
// Loadable down-counter that times every timed phase of the Clock Lane.
//
// Ports:
//   clk      - word clock
//   rst      - synchronous active-high reset, clears the count
//   load     - load load_val this cycle (a new phase is being entered)
//   load_val - value to load, already reduced to phase length minus one
//   zero     - count currently reads 0; the phase ends on this cycle
module d_phy_phase_timer
  import d_phy_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Saturates at 0 instead of wrapping, so a phase that overstays its
  // time keeps reporting expiry until the next load.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/d_phy_clk_lane_ctrl.sv
// MIPI D-PHY master Clock Lane sequencer.
// Takes HS requests from the data lanes and steps the Clock Lane through
// LP-11 -> LP-01 -> LP-00 -> HS-0 -> clock running -> trail -> LP-11.
// Once T_CLK_PRE has elapsed, it grants the data lanes (clk_ready).
//
// Ports:
//   hs_tx_word_clk - word clock; every state change happens on its rising edge
//   rst            - synchronous active-high reset, aborts straight to IDLE
//   hs_req         - per-lane HS request levels; any bit set means a request
//   cfg_t_*        - phase lengths in cycles, captured when a sequence starts
//   lp_dp, lp_dn   - LP driver levels
//   hs_tx_en       - HS driver enabled
//   hs_clk_toggle  - HS clock gate open (0 drives HS-0)
//   clk_ready      - grant to the data lanes
//   busy           - controller not in IDLE
module d_phy_clk_lane_ctrl
  import d_phy_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int CNT_W   = 8
) (
  input  logic               hs_tx_word_clk,
  input  logic               rst,
  input  logic [N_LANES-1:0] hs_req,
  input  logic [CNT_W-1:0]   cfg_t_lpx,
  input  logic [CNT_W-1:0]   cfg_t_prepare,
  input  logic [CNT_W-1:0]   cfg_t_zero,
  input  logic [CNT_W-1:0]   cfg_t_pre,
  input  logic [CNT_W-1:0]   cfg_t_post,
  input  logic [CNT_W-1:0]   cfg_t_trail,
  input  logic [CNT_W-1:0]   cfg_t_exit,
  output logic               lp_dp,
  output logic               lp_dn,
  output logic               hs_tx_en,
  output logic               hs_clk_toggle,
  output logic               clk_ready,
  output logic               busy
);

  clk_lane_state_t state_q, state_d;

  logic [CNT_W-1:0] t_lpx_q, t_lpx_d;
  logic [CNT_W-1:0] t_prepare_q, t_prepare_d;
  logic [CNT_W-1:0] t_zero_q, t_zero_d;
  logic [CNT_W-1:0] t_pre_q, t_pre_d;
  logic [CNT_W-1:0] t_post_q, t_post_d;
  logic [CNT_W-1:0] t_trail_q, t_trail_d;
  logic [CNT_W-1:0] t_exit_q, t_exit_d;

  logic lp_dp_q, lp_dp_d;
  logic lp_dn_q, lp_dn_d;
  logic hs_tx_en_q, hs_tx_en_d;
  logic hs_clk_toggle_q, hs_clk_toggle_d;
  logic clk_ready_q, clk_ready_d;
  logic busy_q, busy_d;

  logic             any_req;
  logic             start_seq;
  logic             timer_zero;
  logic             timer_load;
  logic [CNT_W-1:0] phase_cfg;
  logic [CNT_W-1:0] timer_val;

  // A cfg of 0 still produces a one-cycle phase.
  function automatic logic [CNT_W-1:0] entry_count(input logic [CNT_W-1:0] cfg);
    return (cfg == '0) ? '0 : cfg - 1'b1;
  endfunction

  assign any_req   = |hs_req;
  assign start_seq = (state_q == IDLE) && any_req;

  // Next-state logic. POST checks for a returning request before its
  // timeout, so a request on the last POST cycle still wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req)    state_d = LPX;
      LPX:     if (timer_zero) state_d = PREPARE;
      PREPARE: if (timer_zero) state_d = ZERO;
      ZERO:    if (timer_zero) state_d = PRE;
      PRE:     if (timer_zero) state_d = ACTIVE;
      ACTIVE:  if (!any_req)   state_d = POST;
      POST: begin
        if (any_req) begin
          state_d = ACTIVE;
        end else if (timer_zero) begin
          state_d = TRAIL;
        end
      end
      TRAIL:   if (timer_zero) state_d = EXIT;
      EXIT:    if (timer_zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The shadows capture on the IDLE->LPX edge, so they only hold the new
  // values from the following cycle. The LPX count therefore comes from
  // the live input on that edge.
  always_comb begin
    t_lpx_d     = start_seq ? cfg_t_lpx     : t_lpx_q;
    t_prepare_d = start_seq ? cfg_t_prepare : t_prepare_q;
    t_zero_d    = start_seq ? cfg_t_zero    : t_zero_q;
    t_pre_d     = start_seq ? cfg_t_pre     : t_pre_q;
    t_post_d    = start_seq ? cfg_t_post    : t_post_q;
    t_trail_d   = start_seq ? cfg_t_trail   : t_trail_q;
    t_exit_d    = start_seq ? cfg_t_exit    : t_exit_q;

    phase_cfg = '0;
    case (state_d)
      LPX:     phase_cfg = start_seq ? cfg_t_lpx : t_lpx_q;
      PREPARE: phase_cfg = t_prepare_q;
      ZERO:    phase_cfg = t_zero_q;
      PRE:     phase_cfg = t_pre_q;
      POST:    phase_cfg = t_post_q;
      TRAIL:   phase_cfg = t_trail_q;
      EXIT:    phase_cfg = t_exit_q;
      default: phase_cfg = '0;
    endcase

    timer_load = (state_d != state_q);
    timer_val  = entry_count(phase_cfg);
  end

  // The outputs decode the present state and are registered, so they
  // trail the state register by one cycle.
  always_comb begin
    lp_dp_d         = LOW;
    lp_dn_d         = LOW;
    hs_tx_en_d      = LOW;
    hs_clk_toggle_d = LOW;
    clk_ready_d     = LOW;
    busy_d          = (state_q != IDLE);
    case (state_q)
      IDLE, EXIT: begin
        lp_dp_d = HIGH;
        lp_dn_d = HIGH;
      end
      LPX:     lp_dn_d = HIGH;
      PREPARE: ;
      ZERO, TRAIL: hs_tx_en_d = HIGH;
      PRE, POST: begin
        hs_tx_en_d      = HIGH;
        hs_clk_toggle_d = HIGH;
      end
      ACTIVE: begin
        hs_tx_en_d      = HIGH;
        hs_clk_toggle_d = HIGH;
        clk_ready_d     = HIGH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge hs_tx_word_clk) begin
    if (rst) begin
      state_q         <= IDLE;
      t_lpx_q         <= CNT_W'(T_LPX);
      t_prepare_q     <= CNT_W'(T_CLK_PREPARE);
      t_zero_q        <= CNT_W'(T_CLK_ZERO);
      t_pre_q         <= CNT_W'(T_CLK_PRE);
      t_post_q        <= CNT_W'(T_CLK_POST);
      t_trail_q       <= CNT_W'(T_CLK_TRAIL);
      t_exit_q        <= CNT_W'(T_HS_EXIT);
      lp_dp_q         <= HIGH;
      lp_dn_q         <= HIGH;
      hs_tx_en_q      <= LOW;
      hs_clk_toggle_q <= LOW;
      clk_ready_q     <= LOW;
      busy_q          <= LOW;
    end else begin
      state_q         <= state_d;
      t_lpx_q         <= t_lpx_d;
      t_prepare_q     <= t_prepare_d;
      t_zero_q        <= t_zero_d;
      t_pre_q         <= t_pre_d;
      t_post_q        <= t_post_d;
      t_trail_q       <= t_trail_d;
      t_exit_q        <= t_exit_d;
      lp_dp_q         <= lp_dp_d;
      lp_dn_q         <= lp_dn_d;
      hs_tx_en_q      <= hs_tx_en_d;
      hs_clk_toggle_q <= hs_clk_toggle_d;
      clk_ready_q     <= clk_ready_d;
      busy_q          <= busy_d;
    end
  end

  d_phy_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (hs_tx_word_clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  assign lp_dp         = lp_dp_q;
  assign lp_dn         = lp_dn_q;
  assign hs_tx_en      = hs_tx_en_q;
  assign hs_clk_toggle = hs_clk_toggle_q;
  assign clk_ready     = clk_ready_q;
  assign busy          = busy_q;

endmodule
